hm_rd_sched: RTL and testbench
==============================

Name: hm_rd_sched

Overview:
- Sequences host-memory read jobs for the HM capture path.
- Splits one job (start address, DW count) into PCIe Memory Read requests that respect MAX_RD_DW and 4 KB boundaries.
- Issues the requests one at a time to the TX requester and waits for the RX completion engine's rx_memory_read pulse before issuing the next.
- Provides timeout and link-down error handling, an RX flush pulse and statistics.

Parameters:
MAX_RD_DW, 128, max DWs per read request (power of 2, 1..512; max read request size / 4)
TIMEOUT_CYC, 65535, trn_clk cycles allowed from tx_ack to rx_memory_read (1..2^24-1)

Ports:
trn_clk  in  1  clock
trn_reset_n  in  1  synchronous active-low reset
trn_lnk_up_n  in  1  link up, active-low
job_start  in  1  start pulse; sampled only in IDLE
job_addr  in  64  job byte address; bits [1:0] ignored (DW aligned)
job_dw  in  12  job length in DW, 1..2048; 0 is rejected
job_busy  out  1  high from job acceptance until done/err
job_done  out  1  1-cycle pulse, all chunks completed
job_err  out  1  1-cycle pulse, job aborted
tx_req  out  1  request valid; held until tx_ack
tx_ack  in  1  TX requester has sent the TLP
tx_addr  out  64  chunk byte address, stable while tx_req
tx_len  out  10  chunk length in DW, 1..MAX_RD_DW
rx_memory_read  in  1  pulse: completion(s) for current chunk fully received
rx_rst  out  1  1-cycle pulse to flush the RX engine
stat_state  out  3  current state encoding
stat_chunks  out  32  completed chunks, saturating
stat_timeouts  out  32  timeout events, saturating

Behaviour:
- Clock/reset: single clock trn_clk; reset trn_reset_n is synchronous and active-low.
- Reset values: all outputs 0. State IDLE. Internal address, remaining count and timer all 0.
- State encoding: IDLE=0, CALC=1, ISSUE=2, WAIT=3, NEXT=4, ERR=5.
- IDLE:
  - job_start=1 and job_dw!=0 and trn_lnk_up_n=0: latch addr={job_addr[63:2],2'b00}, rem=job_dw; job_busy<=1; go CALC.
  - job_start=1 with job_dw=0 or link down: job_err pulse next cycle; stay IDLE.
- CALC (1 cycle):
  - to4k = 1024 - addr[11:2].
  - len = min(rem, MAX_RD_DW, to4k).
  - tx_addr<=addr; tx_len<=len; tx_req<=1; go ISSUE.
- ISSUE: hold tx_req/tx_addr/tx_len. On tx_ack: tx_req<=0, timer<=0, go WAIT. tx_ack while tx_req=0 is ignored.
- WAIT:
  - Timer increments each cycle.
  - rx_memory_read=1: addr+=len*4 (64-bit add, carry allowed); rem-=len; stat_chunks++; go NEXT.
  - Timer reaches TIMEOUT_CYC with no rx_memory_read: stat_timeouts++; go ERR.
  - rx_memory_read and the timeout condition in the same cycle: completion wins.
- NEXT:
  - rem==0: job_done pulse; job_busy<=0; go IDLE.
  - Otherwise go CALC. Minimum gap between tx_ack and the next tx_req is 3 cycles.
- ERR (1 cycle): rx_rst pulse, job_err pulse, job_busy<=0, tx_req<=0; go IDLE.
- Link down: trn_lnk_up_n=1 in any state other than IDLE/ERR goes to ERR next cycle. This aborts an outstanding tx_req.
- Outside IDLE: job_start is ignored. rx_memory_read outside WAIT is ignored; it does not count as a completion.
- Reset mid-job: immediate return to IDLE. No done/err pulse. rx_rst is not asserted (the RX engine shares the reset).
- Statistics: counters saturate at 32'hFFFFFFFF and are cleared only by reset.
- Chunk addresses never cross a 4 KB boundary. The sum of tx_len over a job equals job_dw.

Optional Feature:
HM_RD_SCHED_RETRY_EN:
- Defined: a timeout in WAIT goes to a RETRY state instead of ERR.
- RETRY pulses rx_rst, increments the 2-bit retry count, re-issues the same chunk (same tx_addr/tx_len) via ISSUE.
- A 4th consecutive timeout on the same chunk goes to ERR.
- Retry count clears on each successful chunk. stat_timeouts counts every timeout.
- RETRY encoding is 6.
- Undefined: no RETRY state; the first timeout goes to ERR.

Test Plan:
- addr=0x1000, dw=256, MAX_RD_DW=128, tx_ack and rx_memory_read 10 cycles later each -> chunks (0x1000,128), (0x1200,128); job_done once; stat_chunks=2.
- addr=0x1FF0, dw=10 -> chunks (0x1FF0,4), (0x2000,6); no chunk crosses 0x2000.
- addr=0x0, dw=0 -> job_err pulse, job_busy stays 0, no tx_req.
- dw=64, no rx_memory_read, TIMEOUT_CYC=100 -> ERR reached 100 cycles after tx_ack; rx_rst and job_err pulse same cycle; stat_timeouts=1. With HM_RD_SCHED_RETRY_EN: same chunk reissued 3 times, then job_err, stat_timeouts=4.
- trn_lnk_up_n rises while tx_req is held -> tx_req drops next cycle, job_err pulse, state IDLE.
- trn_reset_n=0 in WAIT -> next cycle all outputs 0, state IDLE, no job_done/job_err.

Source files
------------

// File: rtl/hm_rd_sched.sv
// hm_rd_sched: splits host-memory read jobs into 4 KB-safe MRd chunks, one outstanding at a time.
// Define HM_RD_SCHED_RETRY_EN to retry a timed-out chunk up to three times before aborting.
module hm_rd_sched #(
  parameter int MAX_RD_DW   = 128,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        trn_lnk_up_n,
  input  logic        job_start,
  input  logic [63:0] job_addr,
  input  logic [11:0] job_dw,
  output logic        job_busy,
  output logic        job_done,
  output logic        job_err,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [63:0] tx_addr,
  output logic [9:0]  tx_len,
  input  logic        rx_memory_read,
  output logic        rx_rst,
  output logic [2:0]  stat_state,
  output logic [31:0] stat_chunks,
  output logic [31:0] stat_timeouts
);
  localparam logic [2:0] IDLE = 3'd0, CALC = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, NEXT = 3'd4, ERR = 3'd5, RETRY = 3'd6;
  logic [2:0] state, state_n, tmo_dst;
  logic [63:0] addr;
  logic [11:0] rem, len_a, len;
  logic [10:0] to4k;
  logic [23:0] timer;
  logic start_ok, abort, chunk_ok, tmo_hit;
  logic tx_req_d, busy_d, done_d, err_d, rst_d;
`ifdef HM_RD_SCHED_RETRY_EN
  logic [1:0] retry_cnt;
  assign tmo_dst = retry_cnt == 2'd3 ? ERR : RETRY;
`else
  assign tmo_dst = ERR;
`endif
  assign stat_state = state;
  assign start_ok = job_start && job_dw != 12'd0 && !trn_lnk_up_n;
  assign abort = trn_lnk_up_n && state != IDLE && state != ERR;
  assign chunk_ok = state == WAIT && rx_memory_read && !trn_lnk_up_n;
  assign tmo_hit = state == WAIT && !rx_memory_read && !trn_lnk_up_n && timer == 24'(TIMEOUT_CYC - 1);
  assign to4k = 11'd1024 - {1'b0, addr[11:2]};
  assign len_a = rem < 12'(MAX_RD_DW) ? rem : 12'(MAX_RD_DW);
  assign len = len_a < {1'b0, to4k} ? len_a : {1'b0, to4k};
  always_ff @(posedge trn_clk)
    state <= !trn_reset_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start_ok ? CALC : IDLE;
      CALC:  state_n = ISSUE;
      ISSUE: state_n = tx_ack ? WAIT : ISSUE;
      WAIT:  state_n = rx_memory_read ? NEXT : tmo_hit ? tmo_dst : WAIT;
      NEXT:  state_n = rem == 12'd0 ? IDLE : CALC;
`ifdef HM_RD_SCHED_RETRY_EN
      RETRY: state_n = ISSUE;
`endif
      default: state_n = IDLE;
    endcase
    if (abort) state_n = ERR;
  end
  always_comb begin
    tx_req_d = state_n == ISSUE;
    busy_d = state_n != IDLE && state_n != ERR;
    done_d = state == NEXT && state_n == IDLE;
    err_d = (state == IDLE && job_start && !start_ok) || state_n == ERR;
    rst_d = state_n == ERR || state_n == RETRY;
  end
  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      tx_req <= 1'b0;
      job_busy <= 1'b0;
      job_done <= 1'b0;
      job_err <= 1'b0;
      rx_rst <= 1'b0;
      tx_addr <= '0;
      tx_len <= '0;
      addr <= '0;
      rem <= '0;
      timer <= '0;
      stat_chunks <= '0;
      stat_timeouts <= '0;
    end else begin
      tx_req <= tx_req_d;
      job_busy <= busy_d;
      job_done <= done_d;
      job_err <= err_d;
      rx_rst <= rst_d;
      timer <= state == WAIT ? timer + 24'd1 : 24'd0;
      if (state == IDLE && start_ok) begin
        addr <= job_addr & ~64'h3;
        rem <= job_dw;
      end
      if (state == CALC) begin
        tx_addr <= addr;
        tx_len <= len[9:0];
      end
      if (chunk_ok) begin
        addr <= addr + {52'd0, tx_len, 2'b00};
        rem <= rem - {2'b00, tx_len};
        stat_chunks <= &stat_chunks ? stat_chunks : stat_chunks + 32'd1;
      end
      if (tmo_hit) stat_timeouts <= &stat_timeouts ? stat_timeouts : stat_timeouts + 32'd1;
    end
  end
`ifdef HM_RD_SCHED_RETRY_EN
  // count clears per accepted job and per completed chunk, so only consecutive timeouts accumulate
  always_ff @(posedge trn_clk)
    retry_cnt <= !trn_reset_n || state == IDLE || chunk_ok ? 2'd0 : state_n == RETRY ? retry_cnt + 2'd1 : retry_cnt;
`endif
endmodule

// File: tb/tb_hm_rd_sched.sv
// tb_hm_rd_sched: directed jobs with a scoreboard of expected chunks and done/err/rx_rst events.
module tb_hm_rd_sched;
`ifdef HM_RD_SCHED_RETRY_EN
  localparam int NTMO = 4;
`else
  localparam int NTMO = 1;
`endif
  logic trn_clk = 0, trn_reset_n = 0, trn_lnk_up_n = 0, job_start = 0, tx_ack = 0, rx_memory_read = 0;
  logic [63:0] job_addr = 0;
  logic [11:0] job_dw = 0;
  logic job_busy, job_done, job_err, tx_req, rx_rst;
  logic [63:0] tx_addr;
  logic [9:0] tx_len;
  logic [2:0] stat_state;
  logic [31:0] stat_chunks, stat_timeouts;
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] a; logic [9:0] l;} chunk_t;
  chunk_t chunk_q[$];
  logic [2:0] evt_q[$];
  hm_rd_sched #(.MAX_RD_DW(128), .TIMEOUT_CYC(100)) dut (
    .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
    .job_start(job_start), .job_addr(job_addr), .job_dw(job_dw),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .tx_req(tx_req), .tx_ack(tx_ack), .tx_addr(tx_addr), .tx_len(tx_len),
    .rx_memory_read(rx_memory_read), .rx_rst(rx_rst), .stat_state(stat_state),
    .stat_chunks(stat_chunks), .stat_timeouts(stat_timeouts));
  always #5 trn_clk = ~trn_clk;
  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endfunction
  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask
  task automatic push_chunk(input logic [63:0] a, input logic [9:0] l);
    chunk_t c;
    c.a = a;
    c.l = l;
    chunk_q.push_back(c);
  endtask
  // handshake is seen at negedge just before the edge that samples it
  always @(negedge trn_clk) begin
    if (tx_req && tx_ack) begin
      if (chunk_q.size() == 0) chk("chunk_unexpected_addr", tx_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        chunk_t c;
        c = chunk_q.pop_front();
        chk("chunk_addr", tx_addr, c.a);
        chk("chunk_len", {54'd0, tx_len}, {54'd0, c.l});
      end
    end
    if (job_done || job_err || rx_rst) begin
      if (evt_q.size() == 0) chk("evt_unexpected", {61'd0, job_done, job_err, rx_rst}, 64'd0);
      else chk("evt_done_err_rst", {61'd0, job_done, job_err, rx_rst}, {61'd0, evt_q.pop_front()});
    end
  end
  task automatic start_job(input logic [63:0] a, input logic [11:0] dw);
    job_addr = a;
    job_dw = dw;
    job_start = 1;
    tick();
    job_start = 0;
  endtask
  task automatic serve(input int ack_dly, input int rx_dly, input bit rx_en);
    int n = 0;
    while (!tx_req && n < 500) begin tick(); n++; end
    if (!tx_req) begin chk("tx_req_timeout", 64'd0, 64'd1); return; end
    repeat (ack_dly) tick();
    tx_ack = 1;
    tick();
    tx_ack = 0;
    if (rx_en) begin
      repeat (rx_dly - 1) tick();
      rx_memory_read = 1;
      tick();
      rx_memory_read = 0;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((stat_state != 3'd0 || job_busy) && n < 2000) begin tick(); n++; end
    chk("wait_idle_state", {61'd0, stat_state}, 64'd0);
    tick();
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_out"}, {tx_req, job_busy, job_done, job_err, rx_rst, stat_state, tx_len}, 0);
    chk({n, "_addr"}, tx_addr, 0);
    chk({n, "_stats"}, {stat_chunks, stat_timeouts}, 0);
  endtask
  initial begin
    int n;
    repeat (3) tick();
    chk_all_zero("reset");
    trn_reset_n = 1;
    tick();
    push_chunk(64'h1000, 128);
    push_chunk(64'h1200, 128);
    evt_q.push_back(3'b100);
    start_job(64'h1000, 256);
    chk("busy_after_start", {63'd0, job_busy}, 1);
    serve(10, 10, 1);
    serve(10, 10, 1);
    wait_idle();
    chk("chunks_job1", {32'd0, stat_chunks}, 2);
    push_chunk(64'h1FF0, 4);
    push_chunk(64'h2000, 6);
    evt_q.push_back(3'b100);
    start_job(64'h1FF0, 10);
    serve(1, 1, 1);
    serve(0, 3, 1);
    wait_idle();
    chk("chunks_job2", {32'd0, stat_chunks}, 4);
    evt_q.push_back(3'b010);
    start_job(64'h0, 0);
    chk("dw0_busy", {63'd0, job_busy}, 0);
    tick();
    chk("dw0_no_req", {60'd0, tx_req, stat_state}, 0);
    trn_lnk_up_n = 1;
    evt_q.push_back(3'b010);
    start_job(64'h3000, 8);
    chk("lnkdn_start_busy", {60'd0, job_busy, stat_state}, 0);
    trn_lnk_up_n = 0;
    tick();
    for (int i = 0; i < NTMO; i++) begin
      push_chunk(64'h3000, 64);
      evt_q.push_back(i == NTMO - 1 ? 3'b011 : 3'b001);
    end
    start_job(64'h3000, 64);
    for (int i = 0; i < NTMO; i++) begin
      serve(2, 0, 0);
      n = 0;
      while (stat_state == 3'd3 && n < 300) begin tick(); n++; end
      chk("tmo_cycles", n, 100);
      chk("tmo_state", {61'd0, stat_state}, i == NTMO - 1 ? 5 : 6);
    end
    wait_idle();
    chk("tmo_count", {32'd0, stat_timeouts}, NTMO);
    chk("tmo_chunks", {32'd0, stat_chunks}, 4);
    evt_q.push_back(3'b011);
    start_job(64'h4000, 16);
    n = 0;
    while (!tx_req && n < 20) begin tick(); n++; end
    chk("lnk_req_up", {63'd0, tx_req}, 1);
    trn_lnk_up_n = 1;
    tick();
    chk("lnk_abort", {59'd0, tx_req, job_busy, stat_state}, 5);
    tick();
    chk("lnk_idle", {61'd0, stat_state}, 0);
    trn_lnk_up_n = 0;
    tick();
    push_chunk(64'h5000, 8);
    start_job(64'h5000, 8);
    serve(1, 0, 0);
    tick();
    chk("rst_in_wait", {61'd0, stat_state}, 3);
    trn_reset_n = 0;
    tick();
    chk_all_zero("midrst");
    trn_reset_n = 1;
    tick();
    push_chunk(64'hFFC, 1);
    push_chunk(64'h1000, 2);
    evt_q.push_back(3'b100);
    start_job(64'hFFF, 3);
    serve(0, 2, 1);
    serve(0, 2, 1);
    wait_idle();
    push_chunk(64'h1F00, 64);
    push_chunk(64'h2000, 128);
    push_chunk(64'h2200, 108);
    evt_q.push_back(3'b100);
    start_job(64'h1F00, 300);
    repeat (3) serve(1, 1, 1);
    wait_idle();
    chk("chunks_final", {32'd0, stat_chunks}, 5);
    repeat (5) tick();
    chk("chunk_q_left", chunk_q.size(), 0);
    chk("evt_q_left", evt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
